// File: rtl/player_controller.sv
// rtl/player_controller.sv - player sprite position/colour controller with auto-repeat moves.
// Optional build macro CLAMP_EDGES_EN: clamp at screen edges instead of wrapping.
module player_controller #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PLAYER_SIZE  = 12,
  parameter int START_H      = 314,
  parameter int START_V      = 234,
  parameter int STEP         = 1,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  parameter int NUM_COLORS   = 4
) (
  input  logic        btnClk,
  input  logic        rst,
  input  logic [3:0]  btns,
  input  logic        color_btn,
  input  logic        block_up,
  input  logic        block_down,
  input  logic        block_left,
  input  logic        block_right,
  output logic [31:0] player_hPos,
  output logic [31:0] player_vPos,
  output logic [3:0]  player_color,
  output logic        step,
  output logic        bump
);

  localparam logic [31:0] W32      = 32'(SCREEN_W);
  localparam logic [31:0] H32      = 32'(SCREEN_H);
  localparam logic [31:0] SIZE32   = 32'(PLAYER_SIZE);
  localparam logic [31:0] STEP32   = 32'(STEP);
  localparam logic [15:0] delayLoad = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] rateLoad  = 16'(REPEAT_RATE - 1);
  localparam logic [3:0]  lastColor = 4'(NUM_COLORS - 1);

  typedef enum logic {IDLE, HOLD} stateType;

  stateType    state, nextState;
  logic [15:0] count, nextCount;
  logic [3:0]  heldDir, nextDir;
  logic [31:0] nextH, nextV;
  logic        nextStep, nextBump;
  logic        colorPrev;
  logic        btnValid, attempt, blocked;
  logic [31:0] upV, downV, leftH, rightH;

  assign btnValid = (btns == 4'd8) || (btns == 4'd4) || (btns == 4'd2) || (btns == 4'd1);

`ifdef CLAMP_EDGES_EN
  assign upV    = (player_vPos < STEP32) ? 32'd0 : player_vPos - STEP32;
  assign downV  = (player_vPos + SIZE32 + STEP32 > H32) ? H32 - SIZE32 : player_vPos + STEP32;
  assign leftH  = (player_hPos < STEP32) ? 32'd0 : player_hPos - STEP32;
  assign rightH = (player_hPos + SIZE32 + STEP32 > W32) ? W32 - SIZE32 : player_hPos + STEP32;
`else
  assign upV    = (player_vPos < STEP32) ? H32 - SIZE32 : player_vPos - STEP32;
  assign downV  = (player_vPos + SIZE32 + STEP32 > H32) ? 32'd0 : player_vPos + STEP32;
  assign leftH  = (player_hPos < STEP32) ? W32 - SIZE32 : player_hPos - STEP32;
  assign rightH = (player_hPos + SIZE32 + STEP32 > W32) ? 32'd0 : player_hPos + STEP32;
`endif

  always_comb begin
    nextState = state;
    nextCount = count;
    nextDir   = heldDir;
    nextH     = player_hPos;
    nextV     = player_vPos;
    nextStep  = 1'b0;
    nextBump  = 1'b0;
    attempt   = 1'b0;
    blocked   = 1'b0;

    case (state)
      IDLE: begin
        if (btnValid) begin
          attempt   = 1'b1;
          nextDir   = btns;
          nextCount = delayLoad;
          nextState = HOLD;
        end
      end
      HOLD: begin
        if (btns == heldDir) begin
          if (count != 16'd0) begin
            nextCount = count - 16'd1;
          end else begin
            attempt   = 1'b1;
            nextCount = rateLoad;
          end
        end else if (btnValid) begin
          attempt   = 1'b1;
          nextDir   = btns;
          nextCount = delayLoad;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase

    // Every attempt has btns equal to the (re)latched direction.
    if (attempt) begin
      case (btns)
        4'd8: begin blocked = block_up;    nextV = upV;    end
        4'd4: begin blocked = block_down;  nextV = downV;  end
        4'd2: begin blocked = block_right; nextH = rightH; end
        default: begin blocked = block_left; nextH = leftH; end
      endcase
      // A clamped move that lands where it started counts as a bump.
      if (blocked || (nextH == player_hPos && nextV == player_vPos)) begin
        nextH    = player_hPos;
        nextV    = player_vPos;
        nextBump = 1'b1;
      end else begin
        nextStep = 1'b1;
      end
    end
  end

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= 16'd0;
      heldDir      <= 4'd0;
      player_hPos  <= 32'(START_H);
      player_vPos  <= 32'(START_V);
      player_color <= 4'd0;
      step         <= 1'b0;
      bump         <= 1'b0;
      colorPrev    <= 1'b0;
    end else begin
      state       <= nextState;
      count       <= nextCount;
      heldDir     <= nextDir;
      player_hPos <= nextH;
      player_vPos <= nextV;
      step        <= nextStep;
      bump        <= nextBump;
      colorPrev   <= color_btn;
      if (color_btn && !colorPrev)
        player_color <= (player_color == lastColor) ? 4'd0 : player_color + 4'd1;
    end
  end

endmodule

// File: tb/tb_player_controller.sv
// tb/tb_player_controller.sv - directed self-checking bench for player_controller.
module tb_player_controller;

  logic        btnClk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btns = 4'd0;
  logic        color_btn = 1'b0;
  logic        block_up = 1'b0, block_down = 1'b0, block_left = 1'b0, block_right = 1'b0;
  logic [31:0] player_hPos, player_vPos;
  logic [3:0]  player_color;
  logic        step, bump;

  logic [3:0]  topBtns = 4'd0, rightBtns = 4'd0;
  logic [31:0] topH, topV, rightH, rightV;
  logic [3:0]  topColor, rightColor;
  logic        topStep, topBump, rightStep, rightBump;

  int testCnt = 0;
  int failCnt = 0;

  always #5 btnClk = ~btnClk;

  player_controller dut (
    .btnClk(btnClk), .rst(rst), .btns(btns), .color_btn(color_btn),
    .block_up(block_up), .block_down(block_down), .block_left(block_left), .block_right(block_right),
    .player_hPos(player_hPos), .player_vPos(player_vPos), .player_color(player_color),
    .step(step), .bump(bump)
  );

  player_controller #(.START_V(0)) dutTop (
    .btnClk(btnClk), .rst(rst), .btns(topBtns), .color_btn(1'b0),
    .block_up(1'b0), .block_down(1'b0), .block_left(1'b0), .block_right(1'b0),
    .player_hPos(topH), .player_vPos(topV), .player_color(topColor),
    .step(topStep), .bump(topBump)
  );

  player_controller #(.START_H(628)) dutRight (
    .btnClk(btnClk), .rst(rst), .btns(rightBtns), .color_btn(1'b0),
    .block_up(1'b0), .block_down(1'b0), .block_left(1'b0), .block_right(1'b0),
    .player_hPos(rightH), .player_vPos(rightV), .player_color(rightColor),
    .step(rightStep), .bump(rightBump)
  );

  task automatic tick();
    @(posedge btnClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    btns = 4'd0;
    block_up = 1'b0; block_down = 1'b0; block_left = 1'b0; block_right = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    doReset();
    tick();
    check("reset_hPos", player_hPos, 32'd314);
    check("reset_vPos", player_vPos, 32'd234);
    check("reset_color", {28'd0, player_color}, 32'd0);
    check("reset_step", {31'd0, step}, 32'd0);
    check("reset_bump", {31'd0, bump}, 32'd0);

    // Edge wrap / clamp on overridden start positions
    topBtns = 4'd8;
    rightBtns = 4'd2;
    tick();
    topBtns = 4'd0;
    rightBtns = 4'd0;
`ifdef CLAMP_EDGES_EN
    check("edge_up_vPos", topV, 32'd0);
    check("edge_up_bump", {31'd0, topBump}, 32'd1);
    check("edge_up_step", {31'd0, topStep}, 32'd0);
    check("edge_right_hPos", rightH, 32'd628);
    check("edge_right_bump", {31'd0, rightBump}, 32'd1);
    check("edge_right_step", {31'd0, rightStep}, 32'd0);
`else
    check("edge_up_vPos", topV, 32'd468);
    check("edge_up_bump", {31'd0, topBump}, 32'd0);
    check("edge_up_step", {31'd0, topStep}, 32'd1);
    check("edge_right_hPos", rightH, 32'd0);
    check("edge_right_bump", {31'd0, rightBump}, 32'd0);
    check("edge_right_step", {31'd0, rightStep}, 32'd1);
`endif

    // Hold down with auto-repeat: moves on edges 0, 8, 10, 12
    doReset();
    btns = 4'd4;
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("hold_step_e%0d", i), {31'd0, step},
            {31'd0, (i == 0 || i == 8 || i == 10 || i == 12)});
      check($sformatf("hold_bump_e%0d", i), {31'd0, bump}, 32'd0);
    end
    check("hold_vPos", player_vPos, 32'd238);
    check("hold_hPos", player_hPos, 32'd314);

    // Hold down against a wall: bump at the repeat cadence
    doReset();
    block_down = 1'b1;
    btns = 4'd4;
    for (int i = 0; i < 11; i++) begin
      tick();
      check($sformatf("wall_bump_e%0d", i), {31'd0, bump},
            {31'd0, (i == 0 || i == 8 || i == 10)});
      check($sformatf("wall_step_e%0d", i), {31'd0, step}, 32'd0);
    end
    check("wall_vPos", player_vPos, 32'd234);
    block_down = 1'b0;

    // Direction change in HOLD is a fresh press
    doReset();
    btns = 4'd2;
    tick();
    check("right_hPos", player_hPos, 32'd315);
    btns = 4'd1;
    tick();
    check("left_hPos", player_hPos, 32'd314);
    check("left_step", {31'd0, step}, 32'd1);
    btns = 4'd3;
    tick();
    check("multi_hot_step", {31'd0, step}, 32'd0);
    check("multi_hot_hPos", player_hPos, 32'd314);

    // Colour cycling
    doReset();
    for (int k = 1; k <= 5; k++) begin
      color_btn = 1'b1;
      tick();
      check($sformatf("color_%0d", k), {28'd0, player_color}, 32'(k % 4));
      tick();
      color_btn = 1'b0;
      tick();
      tick();
      check($sformatf("color_hold_%0d", k), {28'd0, player_color}, 32'(k % 4));
    end

    // Reset mid-HOLD with button still held
    doReset();
    btns = 4'd4;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_vPos", player_vPos, 32'd235);
    rst = 1'b1;
    #1;
    check("async_rst_vPos", player_vPos, 32'd234);
    tick();
    tick();
    check("in_rst_step", {31'd0, step}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_vPos", player_vPos, 32'd235);
    check("post_rst_step", {31'd0, step}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("post_rst_idle_e%0d", i), {31'd0, step}, 32'd0);
    end
    tick();
    check("post_rst_repeat_vPos", player_vPos, 32'd236);
    check("post_rst_repeat_step", {31'd0, step}, 32'd1);
    btns = 4'd0;

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
